key_repeat_ctrl: RTL and testbench

Consumes the debounced key level (KEY_EN) produced by the switch controller and turns it into key events for the countdown-timer setting logic.
- Emits one KEY_PULSE on press.
- If the key is held and repetition is enabled, emits a further pulse after an initial delay, then one pulse per repeat period.
- All timing is counted in CE ticks (the same prescaled tick that drives the debouncer). It sits between the debouncer and the digit up/down counters.

---
 rtl/key_repeat_ctrl.sv | 123 ++++++++++++
 tb/tb_key_repeat_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: turns the debounced key level into key events.
// One pulse on press; while held with repetition enabled, a further pulse
// after DELAY_TICKS CE ticks and then one every PERIOD_TICKS CE ticks.
module key_repeat_ctrl #(
    parameter int CNT_BITS     = 4,
    parameter int DELAY_TICKS  = 10,
    parameter int PERIOD_TICKS = 3
) (
    input  logic CLK,
    input  logic CLR,
    input  logic CE,
    input  logic KEY_EN,
    input  logic REP_EN,
    output logic KEY_PULSE,
    output logic KEY_HELD,
    output logic REPEATING
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Reload values: the counter expires when it reads zero, so load N-1
    // to get exactly N ticks between pulses.
    localparam logic [CNT_BITS-1:0] DELAY_LOAD  = CNT_BITS'(DELAY_TICKS - 1);
    localparam logic [CNT_BITS-1:0] PERIOD_LOAD = CNT_BITS'(PERIOD_TICKS - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic                pulse_q, pulse_d;
    logic                held_q, held_d;
    logic                rep_q, rep_d;

    // Next-state, counter and event decode; everything holds unless CE is set,
    // except the pulse which defaults low so it is only ever one cycle wide.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        pulse_d = 1'b0;
        if (CE) begin
            // A key must be seen released on at least one tick before a press
            // counts, so a key held through reset does not fire.
            armed_d = ~KEY_EN;
            case (state_q)
                IDLE: begin
                    if (KEY_EN && armed_q) begin
                        pulse_d = 1'b1;
                        cnt_d   = DELAY_LOAD;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (!KEY_EN) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        if (REP_EN) begin
                            pulse_d = 1'b1;
                            cnt_d   = PERIOD_LOAD;
                            state_d = REPEAT;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!KEY_EN) begin
                        state_d = IDLE;
                    end else if (!REP_EN) begin
                        state_d = HOLD;
                    end else if (cnt_q == '0) begin
                        pulse_d = 1'b1;
                        cnt_d   = PERIOD_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                HOLD: begin
                    // Repetition only restarts with a fresh press.
                    if (!KEY_EN) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Status outputs are decodes of the next state so they change on the
        // same edge as the state register.
        held_d = (state_d != IDLE);
        rep_d  = (state_d == REPEAT);
    end

    // State, counter, arm flag and registered outputs.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
            rep_q   <= rep_d;
        end
    end

    assign KEY_PULSE = pulse_q;
    assign KEY_HELD  = held_q;
    assign REPEATING = rep_q;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Testbench for key_repeat_ctrl: one instance with DELAY=10/PERIOD=3 driven by
// sparse CE ticks, one with DELAY=1/PERIOD=1 and CE tied high.
module tb_key_repeat_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b1;

    logic ce_a = 1'b0, ke_a = 1'b0, re_a = 1'b0;
    logic pulse_a, held_a, rep_a;

    logic ce_b = 1'b1, ke_b = 1'b0, re_b = 1'b1;
    logic pulse_b, held_b, rep_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic p;
        logic h;
        logic r;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    key_repeat_ctrl #(.CNT_BITS(4), .DELAY_TICKS(10), .PERIOD_TICKS(3)) dut_a (
        .CLK       (clk),
        .CLR       (clr),
        .CE        (ce_a),
        .KEY_EN    (ke_a),
        .REP_EN    (re_a),
        .KEY_PULSE (pulse_a),
        .KEY_HELD  (held_a),
        .REPEATING (rep_a)
    );

    key_repeat_ctrl #(.CNT_BITS(4), .DELAY_TICKS(1), .PERIOD_TICKS(1)) dut_b (
        .CLK       (clk),
        .CLR       (clr),
        .CE        (ce_b),
        .KEY_EN    (ke_b),
        .REP_EN    (re_b),
        .KEY_PULSE (pulse_b),
        .KEY_HELD  (held_b),
        .REPEATING (rep_b)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic p, input logic h, input logic r);
        exp_t e;
        e.p = p;
        e.h = h;
        e.r = r;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, input logic ap, input logic ah, input logic ar);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=output expected=queued entry (queue empty)", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pulse"}, ap, e.p);
            chk({tag, "_held"},  ah, e.h);
            chk({tag, "_rep"},   ar, e.r);
        end
    endtask

    // One CE tick on instance A, outputs checked one edge later.
    task automatic tick_a(input string tag, input logic ke, input logic re,
                          input logic p, input logic h, input logic r);
        @(negedge clk);
        ke_a = ke;
        re_a = re;
        ce_a = 1'b1;
        push_exp(p, h, r);
        @(posedge clk);
        #1;
        ce_a = 1'b0;
        pop_check(tag, pulse_a, held_a, rep_a);
    endtask

    // CE-low cycles after a tick: pulse must have dropped, status must hold.
    task automatic gap_a(input string tag, input logic h, input logic r);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk({tag, "_gap_pulse"}, pulse_a, 1'b0);
                chk({tag, "_gap_held"},  held_a,  h);
                chk({tag, "_gap_rep"},   rep_a,   r);
            end
        end
    endtask

    task automatic step_a(input string tag, input logic ke, input logic re,
                          input logic p, input logic h, input logic r);
        tick_a(tag, ke, re, p, h, r);
        gap_a(tag, h, r);
    endtask

    initial begin
        logic p;
        // Reset
        #3 clr = 1'b0;
        #1;
        chk("reset_pulse", pulse_a, 1'b0);
        chk("reset_held",  held_a,  1'b0);
        chk("reset_rep",   rep_a,   1'b0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        // Arm with a released tick
        step_a("arm", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Held with repeat: pulses at 0,10,13,16,19
        for (int t = 0; t < 20; t++) begin
            p = (t == 0) || (t == 10) || (t == 13) || (t == 16) || (t == 19);
            step_a($sformatf("rep_t%0d", t), 1'b1, 1'b1, p, 1'b1, (t >= 10));
        end
        step_a("rep_release", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Short press: one pulse, KEY_HELD falls on release tick
        for (int t = 0; t < 5; t++)
            step_a($sformatf("short_t%0d", t), 1'b1, 1'b1, (t == 0), 1'b1, 1'b0);
        step_a("short_release", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step_a("short_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Release on the tick the delay expires: no repeat pulse
        for (int t = 0; t < 10; t++)
            step_a($sformatf("edge_t%0d", t), 1'b1, 1'b1, (t == 0), 1'b1, 1'b0);
        step_a("edge_release", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step_a("edge_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Repeat disabled: single pulse, REP_EN rising at 20 does nothing
        for (int t = 0; t < 30; t++)
            step_a($sformatf("norep_t%0d", t), 1'b1, (t >= 20), (t == 0), 1'b1, 1'b0);
        step_a("norep_release", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while repeating with a pulse showing
        for (int t = 0; t < 14; t++) begin
            p = (t == 0) || (t == 10) || (t == 13);
            if (t < 13)
                step_a($sformatf("rst_t%0d", t), 1'b1, 1'b1, p, 1'b1, (t >= 10));
            else
                tick_a($sformatf("rst_t%0d", t), 1'b1, 1'b1, p, 1'b1, 1'b1);
        end
        clr = 1'b0;
        #1;
        chk("async_pulse", pulse_a, 1'b0);
        chk("async_held",  held_a,  1'b0);
        chk("async_rep",   rep_a,   1'b0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        for (int t = 0; t < 3; t++)
            step_a($sformatf("post_rst_held_t%0d", t), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step_a("post_rst_release", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step_a("post_rst_press", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step_a("post_rst_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Instance B: CE every cycle, DELAY=1, PERIOD=1
        @(negedge clk);
        ke_b = 1'b1;
        for (int e = 0; e < 6; e++) begin
            push_exp(1'b1, 1'b1, (e >= 1));
            @(posedge clk);
            #1;
            pop_check($sformatf("fast_e%0d", e), pulse_b, held_b, rep_b);
        end
        @(negedge clk);
        ke_b = 1'b0;
        for (int e = 0; e < 2; e++) begin
            push_exp(1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            pop_check($sformatf("fast_rel_e%0d", e), pulse_b, held_b, rep_b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
